// File: rtl/forward_network_param.sv
// Result-forwarding network: NUM_PIPES shift chains of DEPTH result
// entries, youngest-match operand bypass, flush squash, collision count.
module forward_network_param #(
    parameter int NUM_PIPES      = 2,
    parameter int DEPTH          = 7,
    parameter int NUM_SRC        = 3,
    parameter int UNIT_ID_SIZE   = 3,
    parameter int REG_ADDR_WIDTH = 7,
    parameter int QUADWORD       = 128,
    parameter int FLUSH_DEPTH    = 3,
    localparam int PKT_W = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PIPES*DEPTH*PKT_W-1:0]       inj_pkt,
    input  logic [NUM_PIPES*NUM_SRC*REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_PIPES*NUM_SRC*QUADWORD-1:0]  rf_data,
    input  logic                                   flush,
    output logic [NUM_PIPES*NUM_SRC*QUADWORD-1:0]  fw_data,
    output logic [NUM_PIPES*NUM_SRC-1:0]           fw_hit,
    output logic [NUM_PIPES*PKT_W-1:0]             wb_pkt,
    output logic                                   collision,
    output logic [15:0]                            collision_cnt
);

    localparam int WE_BIT = QUADWORD + REG_ADDR_WIDTH;
    localparam int NSLOT  = NUM_PIPES * NUM_SRC;

    logic [PKT_W-1:0]           ent_q [NUM_PIPES][DEPTH];
    logic [PKT_W-1:0]           ent_d [NUM_PIPES][DEPTH];
    logic [NUM_PIPES*DEPTH-1:0] col_v;
    logic                       col_q;
    logic [15:0]                cnt_q;
    logic [15:0]                cnt_d;

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        assign wb_pkt[p*PKT_W +: PKT_W] = ent_q[p][DEPTH-1];
        for (genvar k = 0; k < DEPTH; k++) begin : g_ent
            logic [PKT_W-1:0] inj;
            logic [PKT_W-1:0] shf;
            assign inj = inj_pkt[(p*DEPTH+k)*PKT_W +: PKT_W];
            if (k == 0) begin : g_head
                assign shf = inj;
                assign col_v[p*DEPTH+k] = 1'b0;
            end else begin : g_tail
                // a valid injection overwrites whatever was shifting in
                assign shf = inj[WE_BIT] ? inj : ent_q[p][k-1];
                assign col_v[p*DEPTH+k] = inj[WE_BIT] & ent_q[p][k-1][WE_BIT];
            end
            assign ent_d[p][k] = (flush && (k < FLUSH_DEPTH)) ? '0 : shf;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((|col_v) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q <= '{default: '0};
            col_q <= 1'b0;
            cnt_q <= 16'd0;
        end else begin
            ent_q <= ent_d;
            col_q <= |col_v;
            cnt_q <= cnt_d;
        end
    end

    // scan oldest to youngest, pipe 0 first: the last match written wins
    always_comb begin
        fw_data = rf_data;
        fw_hit  = '0;
        for (int sl = 0; sl < NSLOT; sl++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                for (int q = 0; q < NUM_PIPES; q++) begin
                    if (ent_q[q][k][WE_BIT] &&
                        (ent_q[q][k][QUADWORD +: REG_ADDR_WIDTH] ==
                         rd_addr[sl*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
                        fw_hit[sl] = 1'b1;
                        fw_data[sl*QUADWORD +: QUADWORD] =
                            ent_q[q][k][QUADWORD-1:0];
                    end
                end
            end
        end
    end

    assign collision     = col_q;
    assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_forward_network_param.sv
// Directed self-checking bench for forward_network_param.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_forward_network_param;

    localparam int NP = 2;
    localparam int D  = 7;
    localparam int NS = 3;
    localparam int RA = 7;
    localparam int QW = 128;
    localparam int PW = 3 + 1 + RA + QW;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NP*D*PW-1:0]     inj_pkt;
    logic [NP*NS*RA-1:0]    rd_addr;
    logic [NP*NS*QW-1:0]    rf_data;
    logic                   flush;
    logic [NP*NS*QW-1:0]    fw_data;
    logic [NP*NS-1:0]       fw_hit;
    logic [NP*PW-1:0]       wb_pkt;
    logic                   collision;
    logic [15:0]            collision_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    forward_network_param dut (
        .clk          (clk),
        .reset        (reset),
        .inj_pkt      (inj_pkt),
        .rd_addr      (rd_addr),
        .rf_data      (rf_data),
        .flush        (flush),
        .fw_data      (fw_data),
        .fw_hit       (fw_hit),
        .wb_pkt       (wb_pkt),
        .collision    (collision),
        .collision_cnt(collision_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [QW-1:0] DA = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [QW-1:0] DB = 128'hBBBB_0000_BBBB_0000_BBBB_0000_BBBB_0001;
    localparam logic [QW-1:0] DC = 128'hCCCC_1111_CCCC_1111_CCCC_1111_CCCC_1112;
    localparam logic [QW-1:0] DD = 128'hDDDD_2222_DDDD_2222_DDDD_2222_DDDD_2223;
    localparam logic [QW-1:0] DE = 128'hEEEE_3333_EEEE_3333_EEEE_3333_EEEE_3334;
    localparam logic [QW-1:0] DF = 128'hFFFF_4444_FFFF_4444_FFFF_4444_FFFF_4445;

    function automatic logic [PW-1:0] mk(input logic [RA-1:0] a,
                                         input logic [QW-1:0] d);
        return {3'd5, 1'b1, a, d};
    endfunction

    function automatic logic [QW-1:0] rfv(input int s);
        return 128'hFEED_0000_0000_0000_0000_0000_0000_0000 + QW'(s);
    endfunction

    function automatic logic [QW-1:0] fw(input int s);
        return fw_data[s*QW +: QW];
    endfunction

    function automatic logic [PW-1:0] wb(input int p);
        return wb_pkt[p*PW +: PW];
    endfunction

    task automatic set_inj(input int p, input int k, input logic [PW-1:0] pk);
        inj_pkt[(p*D+k-1)*PW +: PW] = pk;
    endtask

    task automatic set_rd(input int s, input logic [RA-1:0] a);
        rd_addr[s*RA +: RA] = a;
        rf_data[s*QW +: QW] = rfv(s);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        inj_pkt = '0;
        flush   = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < NP*D*PW; i++) inj_pkt[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NP*NS*RA; i++) rd_addr[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NP*NS*QW; i++) rf_data[i] = 1'($urandom_range(0, 1));
        flush = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        n_chk++;
        if (wb_pkt !== '0) begin
            $display("FAIL reset_wb: got %h expected 0", wb_pkt); n_fail++;
        end
        n_chk++;
        if (fw_hit !== '0) begin
            $display("FAIL reset_hit: got %b expected 0", fw_hit); n_fail++;
        end
        n_chk++;
        if (fw_data !== rf_data) begin
            $display("FAIL reset_fwdata: got %h expected %h", fw(0), rf_data[QW-1:0]);
            n_fail++;
        end
        n_chk++;
        if (collision_cnt !== 16'd0 || collision !== 1'b0) begin
            $display("FAIL reset_col: got %b/%h expected 0/0", collision, collision_cnt);
            n_fail++;
        end
        clear_inputs();
        reset = 1'b0;
        tick();
        n_chk++;
        if (fw_hit !== '0 || wb_pkt !== '0) begin
            $display("FAIL reset_release: got hit %b wb %h expected 0", fw_hit, wb_pkt);
            n_fail++;
        end
    endtask

    task automatic test_forward;
        do_reset();
        set_rd(0, 7'd5);
        set_rd(1, 7'd6);
        set_rd(5, 7'd5);
        set_inj(0, 2, mk(7'd5, DA));
        tick();
        clear_inputs();
        n_chk++;
        if (fw_hit[0] !== 1'b1 || fw(0) !== DA) begin
            $display("FAIL fwd_hit: got %b %h expected 1 %h", fw_hit[0], fw(0), DA);
            n_fail++;
        end
        n_chk++;
        if (fw_hit[5] !== 1'b1 || fw(5) !== DA) begin
            $display("FAIL fwd_otherpipe: got %b %h expected 1 %h", fw_hit[5], fw(5), DA);
            n_fail++;
        end
        n_chk++;
        if (fw_hit[1] !== 1'b0 || fw(1) !== rfv(1)) begin
            $display("FAIL fwd_miss: got %b %h expected 0 %h", fw_hit[1], fw(1), rfv(1));
            n_fail++;
        end
        for (int i = 2; i <= 7; i++) begin
            tick();
            n_chk++;
            if (wb(0) !== ((i == 6) ? mk(7'd5, DA) : '0)) begin
                $display("FAIL fwd_wb_cycle%0d: got %h", i, wb(0));
                n_fail++;
            end
        end
    endtask

    task automatic test_priority;
        do_reset();
        set_rd(0, 7'd9);
        set_rd(4, 7'd9);
        set_inj(0, 6, mk(7'd9, DB));
        set_inj(1, 3, mk(7'd9, DC));
        tick();
        clear_inputs();
        n_chk++;
        if (fw(0) !== DC || fw_hit[0] !== 1'b1) begin
            $display("FAIL prio_youngest: got %h expected %h", fw(0), DC); n_fail++;
        end
        n_chk++;
        if (fw(4) !== DC) begin
            $display("FAIL prio_youngest_p1: got %h expected %h", fw(4), DC); n_fail++;
        end
        do_reset();
        set_inj(0, 4, mk(7'd9, DD));
        set_inj(1, 4, mk(7'd9, DE));
        tick();
        clear_inputs();
        n_chk++;
        if (fw(0) !== DE) begin
            $display("FAIL prio_tie: got %h expected %h", fw(0), DE); n_fail++;
        end
        tick();
        n_chk++;
        if (fw(4) !== DE) begin
            $display("FAIL prio_tie_shift: got %h expected %h", fw(4), DE); n_fail++;
        end
        set_inj(0, 2, mk(7'd9, DF));
        tick();
        clear_inputs();
        n_chk++;
        if (fw(0) !== DF) begin
            $display("FAIL prio_newer_p0: got %h expected %h", fw(0), DF); n_fail++;
        end
    endtask

    task automatic test_collision;
        do_reset();
        set_rd(0, 7'd20);
        set_rd(1, 7'd21);
        set_inj(0, 3, mk(7'd20, DB));
        tick();
        clear_inputs();
        n_chk++;
        if (collision !== 1'b0) begin
            $display("FAIL col_none: got %b expected 0", collision); n_fail++;
        end
        set_inj(0, 4, mk(7'd21, DC));
        tick();
        clear_inputs();
        n_chk++;
        if (collision !== 1'b1 || collision_cnt !== 16'd1) begin
            $display("FAIL col_pulse: got %b/%0d expected 1/1", collision, collision_cnt);
            n_fail++;
        end
        n_chk++;
        if (fw_hit[0] !== 1'b0 || fw(0) !== rfv(0)) begin
            $display("FAIL col_lost: got %b %h expected 0 %h", fw_hit[0], fw(0), rfv(0));
            n_fail++;
        end
        n_chk++;
        if (fw(1) !== DC) begin
            $display("FAIL col_winner: got %h expected %h", fw(1), DC); n_fail++;
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) begin
                n_chk++;
                if (collision !== 1'b0 || collision_cnt !== 16'd1) begin
                    $display("FAIL col_end: got %b/%0d expected 0/1", collision, collision_cnt);
                    n_fail++;
                end
            end
            n_chk++;
            if (wb(0) !== ((i == 3) ? mk(7'd21, DC) : '0)) begin
                $display("FAIL col_wb_step%0d: got %h", i, wb(0));
                n_fail++;
            end
        end
    endtask

    task automatic test_flush;
        do_reset();
        set_rd(0, 7'd30);
        set_rd(1, 7'd31);
        set_rd(2, 7'd32);
        set_rd(3, 7'd33);
        set_rd(4, 7'd34);
        set_inj(0, 2, mk(7'd30, DA));
        set_inj(0, 3, mk(7'd32, DB));
        set_inj(0, 5, mk(7'd31, DC));
        tick();
        clear_inputs();
        flush = 1'b1;
        set_inj(1, 2, mk(7'd33, DD));
        set_inj(1, 5, mk(7'd34, DE));
        tick();
        clear_inputs();
        n_chk++;
        if (fw_hit[0] !== 1'b0 || fw(0) !== rfv(0)) begin
            $display("FAIL flush_squash: got %b %h expected 0 %h", fw_hit[0], fw(0), rfv(0));
            n_fail++;
        end
        n_chk++;
        if (fw(1) !== DC) begin
            $display("FAIL flush_deep: got %h expected %h", fw(1), DC); n_fail++;
        end
        n_chk++;
        if (fw(2) !== DB) begin
            $display("FAIL flush_boundary: got %h expected %h", fw(2), DB); n_fail++;
        end
        n_chk++;
        if (fw_hit[3] !== 1'b0) begin
            $display("FAIL flush_inj_drop: got %b expected 0", fw_hit[3]); n_fail++;
        end
        n_chk++;
        if (fw(4) !== DE) begin
            $display("FAIL flush_inj_keep: got %h expected %h", fw(4), DE); n_fail++;
        end
        tick();
        n_chk++;
        if (wb(0) !== mk(7'd31, DC) || wb(1) !== '0) begin
            $display("FAIL flush_wb1: got %h expected %h", wb(0), mk(7'd31, DC));
            n_fail++;
        end
        tick();
        n_chk++;
        if (wb(0) !== '0 || wb(1) !== mk(7'd34, DE)) begin
            $display("FAIL flush_wb2: got %h expected %h", wb(1), mk(7'd34, DE));
            n_fail++;
        end
        tick();
        n_chk++;
        if (wb(0) !== mk(7'd32, DB)) begin
            $display("FAIL flush_wb3: got %h expected %h", wb(0), mk(7'd32, DB));
            n_fail++;
        end
    endtask

    task automatic test_saturate_and_reset;
        do_reset();
        set_rd(0, 7'd41);
        set_inj(0, 1, mk(7'd40, DA));
        set_inj(0, 2, mk(7'd41, DB));
        for (int i = 1; i <= 65541; i++) begin
            tick();
            if (i == 3 || i == 65535 || i == 65536) begin
                n_chk++;
                if (collision_cnt !== ((i == 3) ? 16'd2 :
                                       (i == 65535) ? 16'hFFFE : 16'hFFFF)) begin
                    $display("FAIL sat_cnt_tick%0d: got %h", i, collision_cnt);
                    n_fail++;
                end
            end
        end
        n_chk++;
        if (collision_cnt !== 16'hFFFF || collision !== 1'b1) begin
            $display("FAIL sat_hold: got %b/%h expected 1/ffff", collision, collision_cnt);
            n_fail++;
        end
        n_chk++;
        if (wb(0) !== mk(7'd41, DB)) begin
            $display("FAIL sat_inflight: got %h expected %h", wb(0), mk(7'd41, DB));
            n_fail++;
        end
        reset = 1'b1;
        tick();
        n_chk++;
        if (wb_pkt !== '0 || collision_cnt !== 16'd0 || collision !== 1'b0 ||
            fw_hit !== '0) begin
            $display("FAIL midreset: got wb %h cnt %h col %b hit %b expected all 0",
                     wb_pkt, collision_cnt, collision, fw_hit);
            n_fail++;
        end
        clear_inputs();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (wb_pkt !== '0) begin
                $display("FAIL midreset_wb%0d: got %h expected 0", i, wb_pkt);
                n_fail++;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        inj_pkt = '0;
        rd_addr = '0;
        rf_data = '0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_priority();
        test_collision();
        test_flush();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
